word_par_to_ser: RTL and testbench

- Downstream stage of the serial-to-parallel word convertor.
- Accepts one frame of four parallel words (d0..d3) with a valid/ready handshake.
- Re-emits the frame one word per beat on a valid/ready output stream, with index and last-beat flags.
- Feeds the summing/accumulate stages, which consume one word per cycle.

---
 rtl/word_par_to_ser.sv | 171 +++++++++++++++++
 tb/tb_word_par_to_ser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/word_par_to_ser.sv
// Parallel-to-serial word stage: takes a 4-word frame on a valid/ready handshake
// and replays it one word per beat. Optional sum beat via WORD_P2S_SUM_WORD_EN.
//
// state | meaning
// IDLE  | no frame held, in_ready high, out_valid low
// SEND  | frame held, beats presented on out_data until the last one transfers

module word_par_to_ser #(
   parameter int WIDTH     = 32,
   parameter int LSW_FIRST = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_idx,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_cnt
);

`ifdef WORD_P2S_SUM_WORD_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t state_q, state_d;

   // Buffer holds the frame already in emission order, so beat n is simply buf_n.
   logic [WIDTH-1:0] buf0, buf1, buf2, buf3;
   logic [WIDTH-1:0] ord0, ord1, ord2, ord3;
`ifdef WORD_P2S_SUM_WORD_EN
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_in;
`endif

   logic             accept;
   logic             beat;
   logic [2:0]       nxt_idx;
   logic [WIDTH-1:0] nxt_word;

   logic             valid_d;
   logic [2:0]       idx_d;
   logic [WIDTH-1:0] data_d;
   logic             last_d;
   logic [CNT_W-1:0] cnt_d;

   assign ord0 = (LSW_FIRST != 0) ? d0 : d3;
   assign ord1 = (LSW_FIRST != 0) ? d1 : d2;
   assign ord2 = (LSW_FIRST != 0) ? d2 : d1;
   assign ord3 = (LSW_FIRST != 0) ? d3 : d0;

`ifdef WORD_P2S_SUM_WORD_EN
   assign sum_in = d0 + d1 + d2 + d3;
`endif

   assign beat     = out_valid & out_ready;
   assign in_ready = (state_q == IDLE) | (beat & out_last);
   assign accept   = in_valid & in_ready;
   assign nxt_idx  = out_idx + 3'd1;

   always_comb begin
      nxt_word = buf0;
      case (nxt_idx)
         3'd1:    nxt_word = buf1;
         3'd2:    nxt_word = buf2;
         3'd3:    nxt_word = buf3;
`ifdef WORD_P2S_SUM_WORD_EN
         3'd4:    nxt_word = sum_q;
`endif
         default: nxt_word = buf0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      valid_d = out_valid;
      idx_d   = out_idx;
      data_d  = out_data;
      last_d  = out_last;
      cnt_d   = frame_cnt;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SEND;
               valid_d = 1'b1;
               idx_d   = 3'd0;
               data_d  = ord0;
               last_d  = 1'b0;
            end
         end
         SEND: begin
            if (beat) begin
               if (out_last) begin
                  cnt_d = frame_cnt + CNT_W'(1);
                  // A frame accepted on the last beat follows without a bubble.
                  if (accept) begin
                     valid_d = 1'b1;
                     idx_d   = 3'd0;
                     data_d  = ord0;
                     last_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end else begin
                  idx_d  = nxt_idx;
                  data_d = nxt_word;
                  last_d = (nxt_idx == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_idx   <= 3'd0;
         out_data  <= '0;
         out_last  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         out_valid <= valid_d;
         out_idx   <= idx_d;
         out_data  <= data_d;
         out_last  <= last_d;
         frame_cnt <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         buf0 <= '0;
         buf1 <= '0;
         buf2 <= '0;
         buf3 <= '0;
`ifdef WORD_P2S_SUM_WORD_EN
         sum_q <= '0;
`endif
      end else if (accept) begin
         buf0 <= ord0;
         buf1 <= ord1;
         buf2 <= ord2;
         buf3 <= ord3;
`ifdef WORD_P2S_SUM_WORD_EN
         sum_q <= sum_in;
`endif
      end
   end

endmodule

// File: tb/tb_word_par_to_ser.sv
// Bench for word_par_to_ser: two instances (LSW-first/16-bit count and
// MSW-first/2-bit count) share stimulus and are checked against a beat queue.

module tb_word_par_to_ser;

   localparam int W = 32;
`ifdef WORD_P2S_SUM_WORD_EN
   localparam int LASTI = 4;
`else
   localparam int LASTI = 3;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  d0 = '0, d1 = '0, d2 = '0, d3 = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;

   logic          a_in_ready, a_out_valid, a_out_last;
   logic [W-1:0]  a_out_data;
   logic [2:0]    a_out_idx;
   logic [15:0]   a_frame_cnt;
   logic          b_in_ready, b_out_valid, b_out_last;
   logic [W-1:0]  b_out_data;
   logic [2:0]    b_out_idx;
   logic [1:0]    b_frame_cnt;

   always #5 clock = ~clock;

   word_par_to_ser #(.WIDTH(W), .LSW_FIRST(1), .CNT_W(16)) u_a (
      .clock(clock), .reset(reset), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
      .out_last(a_out_last), .frame_cnt(a_frame_cnt));

   word_par_to_ser #(.WIDTH(W), .LSW_FIRST(0), .CNT_W(2)) u_b (
      .clock(clock), .reset(reset), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
      .out_last(b_out_last), .frame_cnt(b_frame_cnt));

   typedef struct packed {
      logic [W-1:0] da;
      logic [W-1:0] db;
      logic [2:0]   idx;
      logic         last;
   } beat_t;

   beat_t q[$];
   beat_t held = '0;
   int    fc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   logic  mon_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected beats of a frame: word order per instance, optional wrapped sum last.
   task automatic push_frame(input logic [W-1:0] w0, w1, w2, w3);
      logic [W-1:0] w[4];
      logic [W-1:0] s;
      beat_t b;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      s = w0 + w1 + w2 + w3;
      for (int i = 0; i <= LASTI; i++) begin
         b.idx  = 3'(i);
         b.last = (i == LASTI);
         b.da   = (i < 4) ? w[i] : s;
         b.db   = (i < 4) ? w[3 - i] : s;
         q.push_back(b);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         logic  exp_v, exp_ir;
         beat_t cur;
         exp_v  = (q.size() != 0);
         cur    = exp_v ? q[0] : held;
         exp_ir = (q.size() == 0) || (out_ready && q.size() == 1);
         check("a_valid", 64'(a_out_valid), 64'(exp_v));
         check("b_valid", 64'(b_out_valid), 64'(exp_v));
         check("a_data", 64'(a_out_data), 64'(cur.da));
         check("b_data", 64'(b_out_data), 64'(cur.db));
         check("a_idx", 64'(a_out_idx), 64'(cur.idx));
         check("b_idx", 64'(b_out_idx), 64'(cur.idx));
         check("a_last", 64'(a_out_last), 64'(cur.last));
         check("b_last", 64'(b_out_last), 64'(cur.last));
         check("a_in_ready", 64'(a_in_ready), 64'(exp_ir));
         check("b_in_ready", 64'(b_in_ready), 64'(exp_ir));
         check("a_frame_cnt", 64'(a_frame_cnt), 64'(fc % 65536));
         check("b_frame_cnt", 64'(b_frame_cnt), 64'(fc % 4));
         if (!reset) begin
            q.delete();
            held = '0;
            fc   = 0;
         end else begin
            if (exp_v && out_ready) begin
               held = q.pop_front();
               if (held.last) fc++;
            end
            if (in_valid && exp_ir) push_frame(d0, d1, d2, d3);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents a frame and returns one edge after it is accepted; in_valid stays high.
   task automatic send_frame(input logic [W-1:0] w0, w1, w2, w3);
      bit done;
      done = 0;
      d0 = w0; d1 = w1; d2 = w2; d3 = w3;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (a_in_ready) done = 1;
         step();
      end
      if (!done) check("accept_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      reset = 1'b0;
      step();
      mon_en = 1'b1;
      step();
      reset = 1'b1;

      send_frame(3, 4, 5, 2);
      in_valid = 1'b0;
      repeat (6) step();

      send_frame(3, 4, 5, 2);
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      repeat (3) step();
      out_ready = 1'b1;
      repeat (6) step();

      send_frame(1, 8, 2, 32'h0400_0004);
      send_frame(32'hA, 32'hB, 32'hC, 32'hD);
      in_valid = 1'b0;
      repeat (7) step();

      send_frame(3, 4, 5, 2);
      in_valid = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      send_frame(3, 4, 5, 2);
      in_valid = 1'b0;
      repeat (6) step();

      for (int f = 0; f < 5; f++) send_frame(3, 4, 5, 2);
      in_valid = 1'b0;
      repeat (7) step();

      send_frame(32'hFFFF_FFFF, 2, 0, 0);
      in_valid = 1'b0;
      repeat (7) step();

      for (int c = 0; c < 600; c++) begin
         d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
         in_valid  = ($urandom_range(1, 0) == 1);
         out_ready = ($urandom_range(9, 0) < 7);
         reset     = ($urandom_range(99, 0) != 0);
         step();
      end
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
